program_loader: RTL



---
 rtl/loader_pkg.sv | 7 +
 rtl/program_loader.sv | 61 ++++++
 2 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared widths, length limit and state type for the program loader
package loader_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_MAX = 1 << ADDR_W;
  typedef enum logic [2:0] {LEN, DATA, CSUM, RUN, ERR} state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed checksummed image into memory and holds the cpu in reset until it verifies
module program_loader
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);
  state_t state, state_n;
  logic [ADDR_W:0] count, n_len;
  logic [DATA_W-1:0] sum;
  logic xfer;
  assign in_ready = state == LEN || state == DATA || state == CSUM;
  assign xfer = in_valid && in_ready;
  assign cpu_rst = state != RUN;
  assign done = state == RUN;
  assign error = state == ERR;
  always_comb begin
    state_n = state;
    case (state)
      LEN: if (in_valid) state_n = (in_data == '0 || 32'(in_data) > LEN_MAX) ? ERR : DATA;
      DATA: if (in_valid && count + 1'b1 == n_len) state_n = CSUM;
      CSUM: if (in_valid) state_n = in_data == sum ? RUN : ERR;
      default: if (reload) state_n = LEN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LEN;
      count <= '0;
      sum <= '0;
      n_len <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      mem_we <= xfer && state == DATA;
      if (xfer && state == LEN) begin
        n_len <= (ADDR_W + 1)'(in_data);
        count <= '0;
        sum <= '0;
      end
      if (xfer && state == DATA) begin
        mem_addr <= count[ADDR_W-1:0];
        mem_wdata <= in_data;
        sum <= sum + in_data;
        count <= count + 1'b1;
      end
    end
  end
endmodule
